// File: rtl/store_lane_buffer.sv
// store_lane_buffer: MEM-stage store path. Narrows a register value onto the
// byte lanes of a word-aligned data-memory write, queues legal stores in a
// small FIFO and issues them over a valid/ready handshake. Misaligned or
// illegal-size stores are dropped and reported through MISALIGN.
module store_lane_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic [31:0]              REQ_ADDR,
    input  logic [31:0]              REQ_DATA,
    input  logic [1:0]               REQ_SIZE,
    output logic                     MEM_VALID,
    input  logic                     MEM_READY,
    output logic [31:0]              MEM_ADDR,
    output logic [31:0]              MEM_WDATA,
    output logic [3:0]               MEM_BE,
    output logic                     MISALIGN,
    output logic [31:0]              MISALIGN_ADDR,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Natural-alignment check; size 11 is never legal.
    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] low);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = ~low[0];
            SIZE_W:  ok = (low == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Replicate the stored value across all lanes so the byte enables alone
    // select which lanes memory actually writes.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] w;
        case (size)
            SIZE_B:  w = {4{data[7:0]}};
            SIZE_H:  w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    // Little-endian byte enables for a legal (already aligned) request.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] low);
        logic [3:0] be;
        case (size)
            SIZE_B:  be = 4'b0001 << low;
            SIZE_H:  be = low[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Entry storage: aligned word address, lane data and enables per slot.
    logic [29:0] ent_addr_q  [DEPTH];
    logic [31:0] ent_wdata_q [DEPTH];
    logic [3:0]  ent_be_q    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             misalign_q, misalign_d;
    logic [31:0]      misalign_addr_q, misalign_addr_d;

    logic accept;
    logic legal;
    logic push;
    logic reject;
    logic pop;
    logic mem_valid;

    // Handshake decode; ready depends only on occupancy, never on MEM_READY.
    always_comb begin
        REQ_READY = (count_q != CNT_FULL);
        mem_valid = (count_q != '0);
        accept    = REQ_VALID & REQ_READY;
        legal     = is_legal(REQ_SIZE, REQ_ADDR[1:0]);
        push      = accept & legal;
        reject    = accept & ~legal;
        pop       = mem_valid & MEM_READY;
    end

    // Next-state for pointers, occupancy and the rejection report.
    always_comb begin
        wr_ptr_d        = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d        = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d         = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        misalign_d      = reject;
        misalign_addr_d = reject ? REQ_ADDR : misalign_addr_q;
    end

    // Control state; asynchronous reset empties the queue immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    // Entry payload is written at accept; contents are only observed while
    // occupied, so the storage itself needs no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            ent_addr_q[wr_ptr_q]  <= REQ_ADDR[31:2];
            ent_wdata_q[wr_ptr_q] <= lane_wdata(REQ_SIZE, REQ_DATA);
            ent_be_q[wr_ptr_q]    <= lane_be(REQ_SIZE, REQ_ADDR[1:0]);
        end
    end

    // Head entry drives memory while valid; outputs read zero when empty.
    always_comb begin
        MEM_VALID     = mem_valid;
        MEM_ADDR      = mem_valid ? {ent_addr_q[rd_ptr_q], 2'b00} : 32'h0;
        MEM_WDATA     = mem_valid ? ent_wdata_q[rd_ptr_q] : 32'h0;
        MEM_BE        = mem_valid ? ent_be_q[rd_ptr_q] : 4'h0;
        MISALIGN      = misalign_q;
        MISALIGN_ADDR = misalign_addr_q;
        COUNT         = count_q;
    end

endmodule

// File: tb/tb_store_lane_buffer.sv
// Directed bench for store_lane_buffer (DEPTH=2) with hand-computed vectors.
`timescale 1ns/1ps
module tb_store_lane_buffer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misalign;
    logic [31:0] misalign_addr;
    logic [1:0]  count;

    int err_cnt = 0;
    int chk_cnt = 0;

    store_lane_buffer #(.DEPTH(2)) dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_ADDR(req_addr), .REQ_DATA(req_data), .REQ_SIZE(req_size),
        .MEM_VALID(mem_valid), .MEM_READY(mem_ready),
        .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_BE(mem_be),
        .MISALIGN(misalign), .MISALIGN_ADDR(misalign_addr), .COUNT(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and checks happen 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        chk({tag, "_valid"}, 32'(mem_valid), 32'd1);
        chk({tag, "_addr"},  mem_addr, a);
        chk({tag, "_wdata"}, mem_wdata, d);
        chk({tag, "_be"},    32'(mem_be), 32'(be));
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        #2;
        // Reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mvalid", 32'(mem_valid), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_mwdata", mem_wdata, 32'h0);
        chk("rst_mbe", 32'(mem_be), 32'h0);
        chk("rst_misaddr", misalign_addr, 32'h0);
        chk("rst_rdy", 32'(req_ready), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // SB sweep, one store at a time
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 32'hAABBCCDD, 2'b00);
            tick();
            drive(1'b0, 32'h0, 32'h0, 2'b00);
            chk("sb_count", 32'(count), 32'd1);
            chk_head("sb", 32'h100, 32'hDDDDDDDD, 4'b0001 << i);
            tick();
            chk("sb_drained", 32'(count), 32'd0);
        end

        // SH then SW
        drive(1'b1, 32'h202, 32'h12345678, 2'b01);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        chk_head("sh", 32'h200, 32'h56785678, 4'b1100);
        tick();
        drive(1'b1, 32'h204, 32'h12345678, 2'b10);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        chk_head("sw", 32'h204, 32'h12345678, 4'b1111);
        tick();
        chk("sw_empty", 32'(mem_valid), 32'd0);
        chk("sw_empty_addr", mem_addr, 32'h0);

        // Misaligned / illegal back-to-back
        drive(1'b1, 32'h301, 32'h1, 2'b01);
        tick();
        chk("mis1", 32'(misalign), 32'd1);
        chk("mis1_addr", misalign_addr, 32'h301);
        chk("mis1_cnt", 32'(count), 32'd0);
        chk("mis1_mv", 32'(mem_valid), 32'd0);
        drive(1'b1, 32'h302, 32'h2, 2'b10);
        tick();
        chk("mis2", 32'(misalign), 32'd1);
        chk("mis2_addr", misalign_addr, 32'h302);
        chk("mis2_mv", 32'(mem_valid), 32'd0);
        drive(1'b1, 32'h300, 32'h3, 2'b11);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        chk("mis3", 32'(misalign), 32'd1);
        chk("mis3_addr", misalign_addr, 32'h300);
        chk("mis3_cnt", 32'(count), 32'd0);
        tick();
        chk("mis_end", 32'(misalign), 32'd0);
        chk("mis_hold", misalign_addr, 32'h300);
        chk("mis_end_mv", 32'(mem_valid), 32'd0);

        // Backpressure / full
        mem_ready = 1'b0;
        drive(1'b1, 32'h400, 32'hA0A0A0A0, 2'b10);
        tick();
        chk("bp_cnt1", 32'(count), 32'd1);
        chk("bp_rdy1", 32'(req_ready), 32'd1);
        drive(1'b1, 32'h404, 32'hA1A1A1A1, 2'b10);
        tick();
        chk("bp_cnt2", 32'(count), 32'd2);
        chk("bp_rdy2", 32'(req_ready), 32'd0);
        drive(1'b1, 32'h408, 32'hA2A2A2A2, 2'b10);
        tick();
        chk("bp_full_cnt", 32'(count), 32'd2);
        chk_head("bp_hold", 32'h400, 32'hA0A0A0A0, 4'hF);
        mem_ready = 1'b1;
        #1;
        chk("bp_rdy_indep", 32'(req_ready), 32'd0);
        tick();
        chk("bp_pop1_cnt", 32'(count), 32'd1);
        chk_head("bp_h2", 32'h404, 32'hA1A1A1A1, 4'hF);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        chk("bp_pp_cnt", 32'(count), 32'd1);
        chk_head("bp_h3", 32'h408, 32'hA2A2A2A2, 4'hF);
        tick();
        chk("bp_empty", 32'(count), 32'd0);

        // Concurrent push/pop with pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i), 2'b10);
            tick();
            chk("cc_cnt", 32'(count), 32'd1);
            chk_head("cc", 32'(i * 4), 32'hC0DE0000 + 32'(i), 4'hF);
        end
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        tick();
        chk("cc_empty", 32'(count), 32'd0);

        // Reset mid-queue
        mem_ready = 1'b0;
        drive(1'b1, 32'h500, 32'h55555555, 2'b10);
        tick();
        drive(1'b1, 32'h504, 32'h66666666, 2'b10);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        chk("mr_cnt", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_mvalid", 32'(mem_valid), 32'd0);
        chk("mr_maddr", mem_addr, 32'h0);
        chk("mr_mwdata", mem_wdata, 32'h0);
        chk("mr_mbe", 32'(mem_be), 32'h0);
        chk("mr_misaddr", misalign_addr, 32'h0);
        #1;
        rst = 1'b0;
        tick();
        mem_ready = 1'b1;
        drive(1'b1, 32'h10, 32'hCAFEF00D, 2'b10);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        chk("mr_cnt_after", 32'(count), 32'd1);
        chk_head("mr_sw", 32'h10, 32'hCAFEF00D, 4'hF);
        tick();
        chk("mr_alone", 32'(mem_valid), 32'd0);
        chk("mr_alone_cnt", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/store_lane_buffer.md
Name: store_lane_buffer

Overview:
- Store-side counterpart of the load-path extension logic in the MEM stage.
- Takes a 32-bit register value plus byte/half/word size and narrows it onto byte lanes of a word-aligned data-memory write, with byte enables.
- Queues stores in a small FIFO and issues them to data memory over a valid/ready handshake.
- Flags misaligned stores to the hazard/exception logic instead of issuing them.

Parameters:
- DEPTH, 2, store buffer entries; power of two, ≥2.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- REQ_VALID  input  1  MEM stage presents a store.
- REQ_READY  output  1  buffer can accept a store.
- REQ_ADDR  input  32  byte address of store.
- REQ_DATA  input  32  rt register value; only low byte/half used for SB/SH.
- REQ_SIZE  input  2  00 byte, 01 half, 10 word, 11 illegal.
- MEM_VALID  output  1  head entry valid toward data memory.
- MEM_READY  input  1  data memory accepts head entry.
- MEM_ADDR  output  32  word-aligned address {addr[31:2],2'b00}.
- MEM_WDATA  output  32  lane-replicated write data.
- MEM_BE  output  4  byte enables; bit i enables bits [8i+7:8i].
- MISALIGN  output  1  one-cycle pulse: a misaligned/illegal store was rejected.
- MISALIGN_ADDR  output  32  REQ_ADDR of the last rejected store.
- COUNT  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Clock is CLK; reset RST is asynchronous, active-high.
- While RST is high:
  - COUNT, MEM_VALID and MISALIGN are 0.
  - MEM_ADDR, MEM_WDATA, MEM_BE and MISALIGN_ADDR are 0.
  - Read/write pointers are 0.
- RST asserted mid-operation discards all queued entries; nothing partial is issued.
- REQ_READY = (COUNT != DEPTH). It is combinational from state only and independent of MEM_READY; no pass-through when full.
- Accept = REQ_VALID & REQ_READY at a rising edge.
- Alignment check on an accepted request:
  - half needs addr[0]=0.
  - word needs addr[1:0]=00.
  - size 11 is always illegal.
- Misaligned or illegal request:
  - Not enqueued.
  - MISALIGN=1 for exactly the following cycle; MISALIGN_ADDR<=REQ_ADDR and holds until the next rejection.
  - Back-to-back rejects keep MISALIGN high on consecutive cycles, with MISALIGN_ADDR updating each time.
- Lane mapping for a legal request (little-endian):
  - byte: WDATA={4{DATA[7:0]}}, BE=4'b0001<<addr[1:0].
  - half: WDATA={2{DATA[15:0]}}, BE = addr[1] ? 4'b1100 : 4'b0011.
  - word: WDATA=DATA, BE=4'b1111.
- Lane mapping is computed at accept and stored per entry, along with the aligned address.
- Issue side:
  - MEM_VALID = (COUNT != 0).
  - MEM_ADDR, MEM_WDATA and MEM_BE are driven from the head entry while MEM_VALID, and are 0 when empty.
  - Pop = MEM_VALID & MEM_READY at an edge.
  - The head is held stable while MEM_VALID & !MEM_READY.
- Latency: a store accepted at edge N is visible on the MEM_* outputs after edge N when the buffer was empty. MEM_VALID is never combinational from REQ_VALID.
- Simultaneous legal push and pop: COUNT unchanged, both pointers advance.
- Push while full is impossible (REQ_READY=0).
- Pop while empty is impossible (MEM_VALID=0).
- Pointers wrap modulo DEPTH. COUNT ranges 0..DEPTH.
- A rejected request concurrent with a pop: only the pop affects COUNT.
- Order is strict FIFO; no merging or forwarding.

Test Plan:
- Reset mid-queue: fill 2 entries, pulse RST asynchronously between edges -> COUNT=0, MEM_VALID=0, MEM_* =0 immediately; a later SW to 0x10 with MEM_READY=1 is issued alone.
- SB sweep: DATA=0xAABBCCDD, addr 0x100..0x103, MEM_READY=1 -> MEM_WDATA=0xDDDDDDDD each time; MEM_BE=0001,0010,0100,1000; MEM_ADDR=0x100.
- SH/SW: SH DATA=0x12345678 @0x202 -> WDATA=0x56785678, BE=1100, ADDR=0x200; SW @0x204 -> WDATA=0x12345678, BE=1111, ADDR=0x204.
- Misalign: SH @0x301, SW @0x302, size 11 @0x300 on consecutive cycles -> MISALIGN high three cycles, MISALIGN_ADDR 0x301,0x302,0x300; COUNT stays 0; no MEM_VALID.
- Backpressure/full: MEM_READY=0, push 3 SW (DEPTH=2) -> REQ_READY=0 after 2 accepts, COUNT=2, head held stable; raise MEM_READY -> issued in order, third accepted once COUNT<2.
- Concurrent push/pop with wrap: MEM_READY=1, REQ_VALID every cycle for 10 SW to 0x0,0x4,… -> COUNT steady at 1, addresses issued in order, pointers wrap cleanly.
